// File: rtl/programmable_tick_timer_if.sv
// rtl/programmable_tick_timer_if.sv - control/status bundle of the programmable tick timer
interface programmable_tick_timer_if #(
  parameter int WIDTH     = 24,
  parameter int CNT_WIDTH = 16
);
  logic                 i_start;
  logic                 i_stop;
  logic                 i_enable;
  logic                 i_mode;
  logic                 i_load;
  logic [WIDTH-1:0]     i_load_value;
  logic                 o_tick;
  logic                 o_done;
  logic                 o_busy;
  logic [WIDTH-1:0]     o_count_out;
  logic [CNT_WIDTH-1:0] o_tick_cnt;

  modport master (
    output i_start, i_stop, i_enable, i_mode, i_load, i_load_value,
    input  o_tick, o_done, o_busy, o_count_out, o_tick_cnt
  );

  modport slave (
    input  i_start, i_stop, i_enable, i_mode, i_load, i_load_value,
    output o_tick, o_done, o_busy, o_count_out, o_tick_cnt
  );
endinterface

// File: rtl/programmable_tick_timer.sv
// rtl/programmable_tick_timer.sv - down-counting tick timer with periodic/one-shot modes
module programmable_tick_timer #(
  parameter int WIDTH          = 24,
  parameter int DEFAULT_PERIOD = 2000000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  programmable_tick_timer_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     L_DEF_PERIOD = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0]     L_ONE        = WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] L_CNT_ONE    = CNT_WIDTH'(1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_period;
  logic [WIDTH-1:0]     r_count;
  logic                 r_tick;
  logic [CNT_WIDTH-1:0] r_tick_cnt;
  logic                 r_mode;

  state_t               w_state_nxt;
  logic [WIDTH-1:0]     w_period_nxt;
  logic [WIDTH-1:0]     w_count_nxt;
  logic                 w_tick_nxt;
  logic [CNT_WIDTH-1:0] w_tick_cnt_nxt;
  logic                 w_mode_nxt;

  // A zero period would never expire, so it is treated as the shortest legal one.
  logic [WIDTH-1:0]     w_load_period;
  // Period to arm with: a load in the same cycle as start/stop takes effect at once.
  logic [WIDTH-1:0]     w_arm_period;

  assign w_load_period = (io_bus.i_load_value == '0) ? L_ONE : io_bus.i_load_value;
  assign w_arm_period  = io_bus.i_load ? w_load_period : r_period;

  // Register all timer state; reset returns to the default period immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_period   <= L_DEF_PERIOD;
      r_count    <= L_DEF_PERIOD - L_ONE;
      r_tick     <= 1'b0;
      r_tick_cnt <= '0;
      r_mode     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_period   <= w_period_nxt;
      r_count    <= w_count_nxt;
      r_tick     <= w_tick_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_mode     <= w_mode_nxt;
    end
  end

  // Next-state logic with stop taking priority over start, start over counting.
  always_comb begin
    w_state_nxt    = r_state;
    w_period_nxt   = w_arm_period;
    w_count_nxt    = r_count;
    w_tick_nxt     = 1'b0;
    w_tick_cnt_nxt = r_tick_cnt;
    w_mode_nxt     = r_mode;

    if (io_bus.i_stop) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = w_arm_period - L_ONE;
    end else if (io_bus.i_start) begin
      w_state_nxt    = S_RUN;
      w_count_nxt    = w_arm_period - L_ONE;
      w_mode_nxt     = io_bus.i_mode;
      w_tick_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (io_bus.i_enable) begin
            if (r_count == '0) begin
              // Reload from the period in force now; a load this cycle applies next time.
              w_tick_nxt     = 1'b1;
              w_count_nxt    = r_period - L_ONE;
              w_tick_cnt_nxt = r_tick_cnt + L_CNT_ONE;
              if (r_mode) begin
                w_state_nxt = S_DONE;
              end
            end else begin
              w_count_nxt = r_count - L_ONE;
            end
          end
        end
        default: begin
          w_count_nxt = w_arm_period - L_ONE;
        end
      endcase
    end
  end

  assign io_bus.o_tick      = r_tick;
  assign io_bus.o_done      = (r_state == S_DONE);
  assign io_bus.o_busy      = (r_state == S_RUN);
  assign io_bus.o_count_out = r_count;
  assign io_bus.o_tick_cnt  = r_tick_cnt;

endmodule

// File: tb/tb_programmable_tick_timer.sv
// tb/tb_programmable_tick_timer.sv - self-checking bench for programmable_tick_timer
module tb_programmable_tick_timer;
  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int DEF = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  programmable_tick_timer_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  programmable_tick_timer #(
    .WIDTH(W), .DEFAULT_PERIOD(DEF), .CNT_WIDTH(CW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 running, 2 finished; ticks kept as an unbounded integer.
  int m_phase, m_period, m_left, m_ticks;
  bit m_oneshot, m_tick;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_period = DEF; m_left = DEF - 1;
      m_ticks = 0; m_oneshot = 0; m_tick = 0;
    end else begin
      int p;
      p = bus.i_load ? ((bus.i_load_value == 0) ? 1 : int'(bus.i_load_value)) : m_period;
      m_tick = 0;
      if (bus.i_stop) begin
        m_phase = 0; m_left = p - 1;
      end else if (bus.i_start) begin
        m_phase = 1; m_left = p - 1; m_oneshot = bus.i_mode; m_ticks = 0;
      end else if (m_phase == 1) begin
        if (bus.i_enable) begin
          if (m_left == 0) begin
            m_tick = 1; m_ticks++; m_left = m_period - 1;
            if (m_oneshot) m_phase = 2;
          end else begin
            m_left--;
          end
        end
      end else begin
        m_left = p - 1;
      end
      m_period = p;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle out of reset, the DUT must agree with the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cmp_tick",  32'(bus.o_tick), 32'(m_tick));
      check("cmp_done",  32'(bus.o_done), 32'(m_phase == 2));
      check("cmp_busy",  32'(bus.o_busy), 32'(m_phase == 1));
      check("cmp_count", 32'(bus.o_count_out), 32'(m_left));
      check("cmp_tcnt",  32'(bus.o_tick_cnt), 32'(m_ticks % (1 << CW)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic ld, input int lv, input logic md);
    bus.i_start = 1'b1; bus.i_load = ld; bus.i_load_value = W'(lv); bus.i_mode = md;
  endtask

  task automatic do_stop();
    bus.i_stop = 1'b1; step(); bus.i_stop = 1'b0;
  endtask

  initial begin
    bus.i_start = 0; bus.i_stop = 0; bus.i_enable = 0; bus.i_mode = 0;
    bus.i_load = 0; bus.i_load_value = '0;
    step(); step();
    check("rst_count", 32'(bus.o_count_out), DEF - 1);
    check("rst_tick",  32'(bus.o_tick), 0);
    check("rst_busy",  32'(bus.o_busy), 0);
    check("rst_done",  32'(bus.o_done), 0);
    check("rst_tcnt",  32'(bus.o_tick_cnt), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: default period 5, periodic
    bus.i_enable = 1'b1;
    arm(1'b0, 0, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) bus.i_start = 1'b0;
      check("t1_tick", 32'(bus.o_tick), 32'(c == 6 || c == 11 || c == 16));
      if (c == 6)  begin check("t1_tcnt6", 32'(bus.o_tick_cnt), 1); check("t1_model6", 32'(m_tick), 1); end
      if (c == 11) check("t1_tcnt11", 32'(bus.o_tick_cnt), 2);
      if (c == 16) begin check("t1_tcnt16", 32'(bus.o_tick_cnt), 3); check("t1_busy", 32'(bus.o_busy), 1); end
    end

    // 2: one-shot with load 3 in the start cycle
    do_stop();
    arm(1'b1, 3, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) begin bus.i_start = 1'b0; bus.i_load = 1'b0; end
      check("t2_tick", 32'(bus.o_tick), 32'(c == 4));
      check("t2_done", 32'(bus.o_done), 32'(c >= 4));
      check("t2_model_done", 32'(m_phase == 2), 32'(c >= 4));
    end

    // 3: pause for three cycles at count 2
    do_stop();
    arm(1'b1, 4, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) begin bus.i_start = 1'b0; bus.i_load = 1'b0; end
      if (c == 2) begin check("t3_count2", 32'(bus.o_count_out), 2); bus.i_enable = 1'b0; end
      if (c >= 3 && c <= 5) check("t3_hold", 32'(bus.o_count_out), 2);
      if (c == 5) bus.i_enable = 1'b1;
      check("t3_tick", 32'(bus.o_tick), 32'(c == 8));
    end

    // 4: load 0 clamps to period 1; tick every cycle, tick_cnt wraps
    do_stop();
    bus.i_load = 1'b1; bus.i_load_value = '0;
    step();
    bus.i_load = 1'b0;
    arm(1'b0, 0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) bus.i_start = 1'b0;
      check("t4_tick", 32'(bus.o_tick), 32'(c >= 2));
      check("t4_tcnt", 32'(bus.o_tick_cnt), 32'((c - 1) % 16));
    end
    check("t4_model_tcnt", 32'(m_ticks), 19);

    // 5: stop+start together, then asynchronous reset mid-run
    bus.i_stop = 1'b1; bus.i_start = 1'b1;
    step();
    bus.i_stop = 1'b0; bus.i_start = 1'b0;
    check("t5_busy", 32'(bus.o_busy), 0);
    check("t5_tick", 32'(bus.o_tick), 0);
    step();
    check("t5_idle_tick", 32'(bus.o_tick), 0);
    arm(1'b0, 0, 1'b0);
    step();
    bus.i_start = 1'b0;
    step(); step(); step();
    check("t5_pre_tick", 32'(bus.o_tick), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_tick",  32'(bus.o_tick), 0);
    check("t5_rst_busy",  32'(bus.o_busy), 0);
    check("t5_rst_count", 32'(bus.o_count_out), DEF - 1);
    check("t5_rst_tcnt",  32'(bus.o_tick_cnt), 0);
    step();
    rst = 1'b0;

    // 6: load 8 while running with period 4
    arm(1'b1, 4, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c == 1) begin bus.i_start = 1'b0; bus.i_load = 1'b0; end
      if (c == 2) begin bus.i_load = 1'b1; bus.i_load_value = 8'd8; end
      if (c == 3) bus.i_load = 1'b0;
      check("t6_tick", 32'(bus.o_tick), 32'(c == 5 || c == 13 || c == 21));
    end

    // Random traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      bus.i_start      = ($urandom_range(0, 29) == 0);
      bus.i_stop       = ($urandom_range(0, 79) == 0);
      bus.i_load       = ($urandom_range(0, 19) == 0);
      bus.i_load_value = W'($urandom_range(0, 12));
      bus.i_enable     = ($urandom_range(0, 9) < 8);
      bus.i_mode       = 1'($urandom_range(0, 1));
      step();
    end
    bus.i_start = 0; bus.i_stop = 0; bus.i_load = 0;
    step();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
